// File: rtl/pred_write_queue_pkg.sv
// Shared predicate-write types, used by the write queue and the predicate register file.
package pred_pkg;

  localparam int unsigned PRED_WIDTH = 32;
  localparam int unsigned PRED_NREGS = 32;
  localparam int unsigned PRED_IDX_W = $clog2(PRED_NREGS);

  typedef logic [PRED_IDX_W-1:0] pred_idx_t;

  // One predicate write request: value plus destination register index.
  typedef struct packed {
    logic [PRED_WIDTH-1:0] msg;
    pred_idx_t             idx;
  } pred_wr_t;

endpackage

// File: rtl/pred_write_queue_if.sv
// Enqueue/dequeue handshake bundle of the predicate write queue.
interface pred_write_queue_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IW    = 5
);

  logic [WIDTH-1:0] enq_msg;
  logic [IW-1:0]    enq_idx;
  logic             enq_val;
  logic             enq_rdy;

  logic [WIDTH-1:0] deq_msg;
  logic [IW-1:0]    deq_idx;
  logic             deq_val;
  logic             deq_rdy;

  // Queue side: accepts from the producer, presents to the register file.
  modport slave (
    input  enq_msg, enq_idx, enq_val, deq_rdy,
    output enq_rdy, deq_msg, deq_idx, deq_val
  );

  // Environment side: producer plus register-file consumer.
  modport master (
    output enq_msg, enq_idx, enq_val, deq_rdy,
    input  enq_rdy, deq_msg, deq_idx, deq_val
  );

endinterface

// File: rtl/pred_write_queue_pending_mask.sv
// Decodes occupied queue entries into a per-register "write in flight" mask.
module pred_pending_mask
  import pred_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned NREGS = 32,
  parameter int unsigned IW    = $clog2(NREGS)
) (
  input  logic [DEPTH-1:0]         occ,
  input  logic [DEPTH-1:0][IW-1:0] idx,
  output logic [NREGS-1:0]         mask
);

  // OR of onehot(idx) over every occupied entry; indices beyond NREGS are ignored.
  always_comb begin
    mask = '0;
    for (int unsigned e = 0; e < DEPTH; e++) begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        if (occ[e] && (idx[e] == IW'(r))) begin
          mask[r] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pred_write_queue.sv
// In-order queue of predicate register writes with a pending-register mask.
module pred_write_queue
  import pred_pkg::*;
#(
  parameter int unsigned WIDTH = PRED_WIDTH,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned NREGS = PRED_NREGS
) (
  input  logic                       clk,
  input  logic                       reset,
  pred_write_queue_if.slave          q,
  output logic [NREGS-1:0]           pending,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned IW = $clog2(NREGS);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [WIDTH-1:0] msg;
    logic [IW-1:0]    idx;
  } entry_t;

  entry_t [DEPTH-1:0] storage_q, storage_d;
  logic   [PW-1:0]    head_q, head_d;
  logic   [PW-1:0]    tail_q, tail_d;
  logic   [CW-1:0]    count_q, count_d;

  logic             enq_fire;
  logic             deq_fire;
  logic [DEPTH-1:0] occ;
  logic [DEPTH-1:0][IW-1:0] occ_idx;

  // Handshake flags and head presentation; rdy depends only on stored state.
  always_comb begin
    q.enq_rdy = (count_q != CW'(DEPTH));
    q.deq_val = (count_q != '0);
    enq_fire  = q.enq_val && q.enq_rdy;
    deq_fire  = q.deq_val && q.deq_rdy;
    q.deq_msg = '0;
    q.deq_idx = '0;
    if (q.deq_val) begin
      q.deq_msg = storage_q[head_q].msg;
      q.deq_idx = storage_q[head_q].idx;
    end
  end

  // Next-state for storage, pointers and occupancy count.
  always_comb begin
    storage_d = storage_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    if (enq_fire) begin
      storage_d[tail_q].msg = q.enq_msg;
      storage_d[tail_q].idx = q.enq_idx;
      tail_d                = tail_q + 1'b1;
    end
    if (deq_fire) begin
      head_d = head_q + 1'b1;
    end
    case ({enq_fire, deq_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Entry e is live when its distance from head (mod DEPTH) is below count.
  always_comb begin
    occ     = '0;
    occ_idx = '0;
    for (int unsigned e = 0; e < DEPTH; e++) begin
      logic [PW-1:0] off;
      off        = PW'(e) - head_q;
      occ[e]     = ({1'b0, off} < count_q);
      occ_idx[e] = storage_q[e].idx;
    end
  end

  pred_pending_mask #(
    .DEPTH (DEPTH),
    .NREGS (NREGS),
    .IW    (IW)
  ) u_pending (
    .occ  (occ),
    .idx  (occ_idx),
    .mask (pending)
  );

  assign count = count_q;

  // Pointer and count registers; reset wins over any same-cycle transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage is data-only and deliberately left unreset.
  always_ff @(posedge clk) begin
    storage_q <= storage_d;
  end

endmodule

// File: tb/tb_pred_write_queue.sv
// Directed scoreboard bench for pred_write_queue.
module tb_pred_write_queue;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned NREGS = 32;
  localparam int unsigned IW    = 5;

  typedef struct {
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] msg;
    int               stamp;
  } sb_t;

  logic clk = 1'b0;
  logic reset;
  logic [NREGS-1:0] pending;
  logic [$clog2(DEPTH):0] count;

  pred_write_queue_if #(.WIDTH(WIDTH), .IW(IW)) bus ();

  pred_write_queue #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .NREGS (NREGS)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .q       (bus.slave),
    .pending (pending),
    .count   (count)
  );

  always #5 clk = ~clk;

  sb_t sb[$];
  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  lat_from = -1;
  int  delivered = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: check outputs against the model at negedge, then advance the model.
  task automatic tick();
    logic [NREGS-1:0] exp_pend;
    int unsigned n;
    @(negedge clk);
    n = sb.size();
    if (reset) begin
      sb.delete();
    end else begin
      exp_pend = '0;
      foreach (sb[k]) exp_pend[sb[k].idx] = 1'b1;
      chk("count",   64'(count),       64'(n));
      chk("enq_rdy", 64'(bus.enq_rdy), 64'(n != DEPTH));
      chk("deq_val", 64'(bus.deq_val), 64'(n != 0));
      chk("pending", 64'(pending),     64'(exp_pend));
      if (n == 0) begin
        chk("deq_msg_idle", 64'(bus.deq_msg), 64'h0);
        chk("deq_idx_idle", 64'(bus.deq_idx), 64'h0);
      end else begin
        chk("deq_msg", 64'(bus.deq_msg), 64'(sb[0].msg));
        chk("deq_idx", 64'(bus.deq_idx), 64'(sb[0].idx));
      end
      if (n != 0 && bus.deq_rdy) begin
        if (lat_from >= 0 && sb[0].stamp >= lat_from)
          chk("latency", 64'(cyc - sb[0].stamp), 64'd2);
        void'(sb.pop_front());
        delivered++;
      end
      if (bus.enq_val && n != DEPTH)
        sb.push_back('{idx: bus.enq_idx, msg: bus.enq_msg, stamp: cyc});
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input logic ev, input logic [IW-1:0] idx,
                       input logic [WIDTH-1:0] msg, input logic dr);
    bus.enq_val = ev;
    bus.enq_idx = idx;
    bus.enq_msg = msg;
    bus.deq_rdy = dr;
  endtask

  initial begin
    int d0;
    reset = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    tick();
    reset = 1'b0;

    // 1: idle after reset
    for (int i = 0; i < 3; i++) tick();

    // 2: fill with consumer stalled, then refused 5th enqueue
    drive(1'b1, 5'd3,  32'hDEAD_BEEF, 1'b0); tick();
    drive(1'b1, 5'd7,  32'h1,         1'b0); tick();
    drive(1'b1, 5'd3,  32'h2,         1'b0); tick();
    drive(1'b1, 5'd31, 32'hFFFF_FFFF, 1'b0); tick();
    chk("full_pending", 64'(pending), 64'h8000_0088);
    drive(1'b1, 5'd9,  32'h5555,      1'b0); tick();
    drive(1'b0, 5'd9,  32'h5555,      1'b0); tick();

    // 3: drain in order
    d0 = delivered;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, '0, 1'b1);
      tick();
    end
    chk("drained_n", 64'(delivered - d0), 64'd4);
    drive(1'b0, '0, '0, 1'b0); tick();

    // 4: steady streaming at occupancy 2
    drive(1'b1, 5'd1, 32'h100, 1'b0); tick();
    drive(1'b1, 5'd2, 32'h101, 1'b0); tick();
    lat_from = cyc;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 5'(i + 10), 32'h200 + 32'(i), 1'b1);
      tick();
    end
    lat_from = -1;
    drive(1'b0, '0, '0, 1'b1); tick(); tick();
    drive(1'b0, '0, '0, 1'b0); tick();

    // 5: enqueue into empty with consumer ready
    drive(1'b1, 5'd5, 32'hA, 1'b1); tick();
    drive(1'b0, 5'd5, 32'hA, 1'b1); tick();
    drive(1'b0, '0, '0, 1'b0); tick();

    // 6: reset while active discards everything
    drive(1'b1, 5'd4, 32'h44, 1'b0); tick();
    drive(1'b1, 5'd6, 32'h66, 1'b0); tick();
    drive(1'b1, 5'd8, 32'h88, 1'b0); tick();
    d0 = delivered;
    drive(1'b1, 5'd9, 32'h99, 1'b1);
    reset = 1'b1; tick(); reset = 1'b0;
    drive(1'b0, '0, '0, 1'b1); tick(); tick();
    chk("reset_no_deliver", 64'(delivered - d0), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
